gelato_inst_fetch_mo: RTL and testbench
=======================================

GELATO_INST_FETCH_MO -- requirements
Module: gelato_inst_fetch_mo

Interface
Parameters
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: PC and cache address width.
REQ-002 SHALL have parameter INST_WIDTH, default 32: instruction word width.
REQ-003 SHALL have parameter WARP_NUM_WIDTH, default 5: warp id width.
REQ-004 SHALL have parameter SPLIT_NUM_WIDTH, default 3: split-table index width.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4: in-flight slots, power of two, at least 2.
REQ-006 SHALL derive TAG_WIDTH = $clog2(MAX_OUTSTANDING).

Ports
REQ-007 SHALL have the following ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  global enable; when low, all state holds and no handshake completes.
- flush  in  1  squash all in-flight fetches.
- pc_valid  in  1  scheduler offers a PC.
- pc_ready  out  1  fetch unit accepts the offered PC.
- pc_addr  in  ADDR_WIDTH  PC.
- pc_warp_num  in  WARP_NUM_WIDTH  warp id.
- pc_split_num  in  SPLIT_NUM_WIDTH  split-table index.
- req_valid  out  1  cache read request.
- req_ready  in  1  cache accepts the request.
- req_addr  out  ADDR_WIDTH  request address.
- req_tag  out  TAG_WIDTH  slot tag.
- rsp_valid  in  1  cache response; always accepted, may return out of order.
- rsp_tag  in  TAG_WIDTH  response tag.
- rsp_data  in  INST_WIDTH  instruction word.
- out_valid  out  1  fetched instruction to decode.
- out_ready  in  1  decode accepts the instruction.
- out_pc  out  ADDR_WIDTH  PC.
- out_warp_num  out  WARP_NUM_WIDTH  warp id.
- out_split_num  out  SPLIT_NUM_WIDTH  split-table index.
- out_inst  out  INST_WIDTH  instruction word.

Function
REQ-008 SHALL hold MAX_OUTSTANDING slots as a circular buffer with head and tail pointers and a full/empty count; each slot stores pc, warp, split, inst, busy, done and squashed bits.
REQ-009 SHALL assert pc_ready = rdy && !flush && (count < MAX_OUTSTANDING) && (!req_valid || req_ready), combinationally.
REQ-010 SHALL, on a pc handshake, in the same edge allocate the tail slot (busy=1, done=0, squashed=0), advance the tail, and register req_valid=1 with req_addr=pc_addr and req_tag=tail index.
REQ-011 SHALL hold req_valid, req_addr and req_tag stable until req_ready; req_valid drops the cycle after acceptance unless a new PC is accepted on the same edge.
REQ-012 SHALL, on rsp_valid, write rsp_data into slot rsp_tag and set done; a response to a non-busy slot is ignored.
REQ-013 SHALL drive out_valid = head slot busy && done && !squashed, combinationally from registered state, with out_* taken from the head slot; latency from response to out_valid is 1 cycle.
REQ-014 SHALL, on an out_valid && out_ready handshake, free the head slot and advance the head; delivery is strictly in allocation order regardless of response order.
REQ-015 SHALL free a head slot that is done && squashed without asserting out_valid.
REQ-016 SHALL, on flush, set squashed on every busy slot and drop a pending unaccepted request (req_valid=0; that slot is marked done, since no response will return); a request already accepted is left in flight, and its slot is freed when its response returns and it reaches head.
REQ-017 SHALL support allocate, response and retire on the same edge; full with a simultaneous retire does not allow an allocation in that cycle, because pc_ready uses the registered count.
REQ-018 SHALL wrap pointers modulo MAX_OUTSTANDING.

Reset
REQ-019 SHALL, on rst_n low, asynchronously clear head, tail, count and every busy/done/squashed bit, and set req_valid=0, req_addr=0 and req_tag=0; out_valid is then 0 and pc_ready follows REQ-009.
REQ-020 SHALL treat reset mid-operation as abandoning all in-flight fetches; stale responses after reset hit non-busy slots and are ignored.

Structure
REQ-021 SHALL place the per-slot entry struct and the default width constants in package gelato_fetch_pkg.
REQ-022 SHALL implement the slot array as sub-module gelato_ifetch_slot_buf, which owns the pointers and storage; the top-level module owns the request register and the handshakes.

Verification
REQ-023 Single fetch: pc 0x100, warp 3; cache ready, responds 2 cycles later with 0xDEADBEEF -> one out beat {0x100, 3, 0xDEADBEEF} 1 cycle after the response.
REQ-024 Out-of-order: PCs 0x0, 0x4, 0x8 issued; responses arrive in tag order 2, 0, 1 -> outputs appear in order 0x0, 0x4, 0x8.
REQ-025 Full: 4 PCs accepted and no responses -> pc_ready=0; one response plus retire -> pc_ready returns to 1 the next cycle.
REQ-026 Backpressure: out_ready=0 for 5 cycles with a done head -> out_* stable, no loss; req_ready=0 -> req_addr and req_tag held.
REQ-027 Flush: 3 in flight, flush, then their responses return -> no out beats; a PC issued after the flush is delivered normally.
REQ-028 Reset: rst_n pulsed while 2 are in flight -> all outputs at reset values; late responses are ignored.

Source files
------------

// File: rtl/gelato_fetch_pkg.sv
// Shared width defaults and per-slot status type for the GELATO instruction fetch unit.
package gelato_fetch_pkg;

  localparam int unsigned DEF_ADDR_WIDTH      = 32;
  localparam int unsigned DEF_INST_WIDTH      = 32;
  localparam int unsigned DEF_WARP_NUM_WIDTH  = 5;
  localparam int unsigned DEF_SPLIT_NUM_WIDTH = 3;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;

  // Lifecycle bits of one in-flight slot; payload widths are per-instance parameters.
  typedef struct packed {
    logic busy;
    logic done;
    logic squashed;
  } slot_flags_t;

endpackage

// File: rtl/gelato_ifetch_slot_buf.sv
// Circular buffer of in-flight fetch slots: owns head/tail pointers, occupancy and slot storage.
module gelato_ifetch_slot_buf
  import gelato_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int unsigned INST_WIDTH      = DEF_INST_WIDTH,
  parameter int unsigned WARP_NUM_WIDTH  = DEF_WARP_NUM_WIDTH,
  parameter int unsigned SPLIT_NUM_WIDTH = DEF_SPLIT_NUM_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned TAG_WIDTH       = $clog2(MAX_OUTSTANDING)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc,
  input  logic [ADDR_WIDTH-1:0]      alloc_pc,
  input  logic [WARP_NUM_WIDTH-1:0]  alloc_warp,
  input  logic [SPLIT_NUM_WIDTH-1:0] alloc_split,
  input  logic                       rsp_wr,
  input  logic [TAG_WIDTH-1:0]       rsp_tag,
  input  logic [INST_WIDTH-1:0]      rsp_data,
  input  logic                       retire,
  input  logic                       squash_all,
  input  logic                       drop,
  input  logic [TAG_WIDTH-1:0]       drop_tag,
  output logic [TAG_WIDTH-1:0]       tail,
  output logic [TAG_WIDTH:0]         count,
  output slot_flags_t                head_flags_c,
  output logic [ADDR_WIDTH-1:0]      head_pc_c,
  output logic [WARP_NUM_WIDTH-1:0]  head_warp_c,
  output logic [SPLIT_NUM_WIDTH-1:0] head_split_c,
  output logic [INST_WIDTH-1:0]      head_inst_c
);

  localparam int unsigned CNT_W = TAG_WIDTH + 1;

  logic [TAG_WIDTH-1:0]       head;
  slot_flags_t                flags     [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-1:0]      pc_mem    [MAX_OUTSTANDING];
  logic [WARP_NUM_WIDTH-1:0]  warp_mem  [MAX_OUTSTANDING];
  logic [SPLIT_NUM_WIDTH-1:0] split_mem [MAX_OUTSTANDING];
  logic [INST_WIDTH-1:0]      inst_mem  [MAX_OUTSTANDING];

  // Pointers wrap naturally since MAX_OUTSTANDING is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (retire) head <= head + TAG_WIDTH'(1);
      if (alloc)  tail <= tail + TAG_WIDTH'(1);
      case ({alloc, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Later writes take priority: retire/alloc reinitialise a slot over response/squash updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        flags[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        if (rsp_wr && (rsp_tag == TAG_WIDTH'(i)) && flags[i].busy) flags[i].done <= 1'b1;
        if (squash_all && flags[i].busy) flags[i].squashed <= 1'b1;
        if (drop && (drop_tag == TAG_WIDTH'(i))) flags[i].done <= 1'b1;
        if (retire && (head == TAG_WIDTH'(i))) flags[i] <= '0;
        if (alloc && (tail == TAG_WIDTH'(i))) flags[i] <= '{busy: 1'b1, done: 1'b0, squashed: 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        pc_mem[i]    <= '0;
        warp_mem[i]  <= '0;
        split_mem[i] <= '0;
        inst_mem[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        if (alloc && (tail == TAG_WIDTH'(i))) begin
          pc_mem[i]    <= alloc_pc;
          warp_mem[i]  <= alloc_warp;
          split_mem[i] <= alloc_split;
        end
        if (rsp_wr && (rsp_tag == TAG_WIDTH'(i)) && flags[i].busy) inst_mem[i] <= rsp_data;
      end
    end
  end

  assign head_flags_c = flags[head];
  assign head_pc_c    = pc_mem[head];
  assign head_warp_c  = warp_mem[head];
  assign head_split_c = split_mem[head];
  assign head_inst_c  = inst_mem[head];

endmodule

// File: rtl/gelato_inst_fetch_mo.sv
// Instruction fetch unit: accepts warp PCs, issues tagged cache reads, delivers instructions in order.
module gelato_inst_fetch_mo
  import gelato_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int unsigned INST_WIDTH      = DEF_INST_WIDTH,
  parameter int unsigned WARP_NUM_WIDTH  = DEF_WARP_NUM_WIDTH,
  parameter int unsigned SPLIT_NUM_WIDTH = DEF_SPLIT_NUM_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  localparam int unsigned TAG_WIDTH      = $clog2(MAX_OUTSTANDING)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       pc_valid,
  output logic                       pc_ready,
  input  logic [ADDR_WIDTH-1:0]      pc_addr,
  input  logic [WARP_NUM_WIDTH-1:0]  pc_warp_num,
  input  logic [SPLIT_NUM_WIDTH-1:0] pc_split_num,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [ADDR_WIDTH-1:0]      req_addr,
  output logic [TAG_WIDTH-1:0]       req_tag,
  input  logic                       rsp_valid,
  input  logic [TAG_WIDTH-1:0]       rsp_tag,
  input  logic [INST_WIDTH-1:0]      rsp_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_WIDTH-1:0]      out_pc,
  output logic [WARP_NUM_WIDTH-1:0]  out_warp_num,
  output logic [SPLIT_NUM_WIDTH-1:0] out_split_num,
  output logic [INST_WIDTH-1:0]      out_inst
);

  localparam int unsigned CNT_W = TAG_WIDTH + 1;

  logic [TAG_WIDTH-1:0] tail;
  logic [CNT_W-1:0]     count;
  slot_flags_t          head_flags;
  logic                 pc_fire;
  logic                 req_fire;
  logic                 rsp_wr;
  logic                 retire;
  logic                 squash_all;
  logic                 drop;

  // Handshakes; every state change is gated by the global enable.
  assign pc_ready   = rdy && !flush && (count < CNT_W'(MAX_OUTSTANDING)) && (!req_valid || req_ready);
  assign pc_fire    = pc_valid && pc_ready;
  assign req_fire   = rdy && req_valid && req_ready;
  assign rsp_wr     = rdy && rsp_valid;
  assign squash_all = rdy && flush;
  // An unaccepted request is withdrawn on flush; its slot will never see a response.
  assign drop       = rdy && flush && req_valid && !req_ready;
  assign out_valid  = head_flags.busy && head_flags.done && !head_flags.squashed;
  assign retire     = rdy && head_flags.busy && head_flags.done && (head_flags.squashed || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_tag   <= '0;
    end else if (rdy) begin
      if (flush) begin
        req_valid <= 1'b0;
      end else if (pc_fire) begin
        req_valid <= 1'b1;
        req_addr  <= pc_addr;
        req_tag   <= tail;
      end else if (req_fire) begin
        req_valid <= 1'b0;
      end
    end
  end

  gelato_ifetch_slot_buf #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .INST_WIDTH      (INST_WIDTH),
    .WARP_NUM_WIDTH  (WARP_NUM_WIDTH),
    .SPLIT_NUM_WIDTH (SPLIT_NUM_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .TAG_WIDTH       (TAG_WIDTH)
  ) u_slot_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc        (pc_fire),
    .alloc_pc     (pc_addr),
    .alloc_warp   (pc_warp_num),
    .alloc_split  (pc_split_num),
    .rsp_wr       (rsp_wr),
    .rsp_tag      (rsp_tag),
    .rsp_data     (rsp_data),
    .retire       (retire),
    .squash_all   (squash_all),
    .drop         (drop),
    .drop_tag     (req_tag),
    .tail         (tail),
    .count        (count),
    .head_flags_c (head_flags),
    .head_pc_c    (out_pc),
    .head_warp_c  (out_warp_num),
    .head_split_c (out_split_num),
    .head_inst_c  (out_inst)
  );

endmodule

// File: tb/tb_gelato_inst_fetch_mo.sv
// Self-checking bench for gelato_inst_fetch_mo: directed scenarios plus randomized traffic vs a queue model.
`timescale 1ns/1ps
module tb_gelato_inst_fetch_mo;

  localparam int unsigned AW   = 32;
  localparam int unsigned IW   = 32;
  localparam int unsigned WW   = 5;
  localparam int unsigned SW   = 3;
  localparam int unsigned MAXO = 4;
  localparam int unsigned TW   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rdy, flush, pc_valid, req_ready, rsp_valid, out_ready;
  logic          pc_ready, req_valid, out_valid;
  logic [AW-1:0] pc_addr, req_addr, out_pc;
  logic [WW-1:0] pc_warp_num, out_warp_num;
  logic [SW-1:0] pc_split_num, out_split_num;
  logic [TW-1:0] req_tag, rsp_tag;
  logic [IW-1:0] rsp_data, out_inst;

  always #5 clk = ~clk;

  gelato_inst_fetch_mo #(
    .ADDR_WIDTH(AW), .INST_WIDTH(IW), .WARP_NUM_WIDTH(WW),
    .SPLIT_NUM_WIDTH(SW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .pc_valid(pc_valid), .pc_ready(pc_ready), .pc_addr(pc_addr),
    .pc_warp_num(pc_warp_num), .pc_split_num(pc_split_num),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_warp_num(out_warp_num), .out_split_num(out_split_num), .out_inst(out_inst)
  );

  // Reference model: fetches in allocation order, plus the cache's list of accepted tags.
  typedef struct {
    logic [AW-1:0] pc;
    logic [WW-1:0] warp;
    logic [SW-1:0] split;
    logic [IW-1:0] inst;
    bit            done;
    bit            sq;
    int            tag;
  } ent_t;

  ent_t          mq[$];
  int            cache_q[$];
  bit            m_req_v;
  logic [AW-1:0] m_req_addr;
  int            m_req_tag;
  int            m_alloc_cnt;
  int            n_checks = 0;
  int            n_errors = 0;

  function automatic bit exp_pc_ready();
    return rdy && !flush && (mq.size() < int'(MAXO)) && (!m_req_v || req_ready);
  endfunction

  function automatic bit exp_out_valid();
    if (mq.size() == 0) return 1'b0;
    return mq[0].done && !mq[0].sq;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_req_v     = 1'b0;
    m_req_addr  = '0;
    m_req_tag   = 0;
    m_alloc_cnt = 0;
  endfunction

  function automatic void model_apply();
    bit   pr, ret, acc;
    ent_t e;
    if (!rdy) return;
    pr  = exp_pc_ready();
    ret = 1'b0;
    if (mq.size() > 0) ret = mq[0].done && (mq[0].sq || out_ready);
    acc = m_req_v && req_ready;
    if (rsp_valid) begin
      foreach (mq[i]) if (mq[i].tag == int'(rsp_tag)) begin mq[i].done = 1'b1; mq[i].inst = rsp_data; end
    end
    if (flush) begin
      foreach (mq[i]) begin
        mq[i].sq = 1'b1;
        if (m_req_v && !req_ready && mq[i].tag == m_req_tag) mq[i].done = 1'b1;
      end
    end
    if (acc) cache_q.push_back(m_req_tag);
    if (ret) void'(mq.pop_front());
    if (flush) begin
      m_req_v = 1'b0;
    end else if (pc_valid && pr) begin
      e.pc = pc_addr; e.warp = pc_warp_num; e.split = pc_split_num; e.inst = '0;
      e.done = 1'b0; e.sq = 1'b0; e.tag = m_alloc_cnt % int'(MAXO);
      m_alloc_cnt++;
      mq.push_back(e);
      m_req_v = 1'b1; m_req_addr = pc_addr; m_req_tag = e.tag;
    end else if (acc) begin
      m_req_v = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_apply();
    @(negedge clk);
  endtask

  task automatic idle();
    rdy = 1'b1; flush = 1'b0; pc_valid = 1'b0; req_ready = 1'b1;
    rsp_valid = 1'b0; out_ready = 1'b1;
    pc_addr = '0; pc_warp_num = '0; pc_split_num = '0; rsp_tag = '0; rsp_data = '0;
  endtask

  task automatic respond(input int tag, input logic [IW-1:0] data);
    rsp_valid = 1'b1; rsp_tag = TW'(tag); rsp_data = data;
    for (int i = 0; i < cache_q.size(); i++) begin
      if (cache_q[i] == tag) begin cache_q.delete(i); break; end
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    idle();
    while ((mq.size() > 0 || m_req_v || cache_q.size() > 0) && guard < 200) begin
      if (cache_q.size() > 0) respond(cache_q[0], $urandom); else rsp_valid = 1'b0;
      tick();
      rsp_valid = 1'b0;
      guard++;
    end
    n_checks++;
    if (mq.size() != 0 || m_req_v) begin
      n_errors++; $display("FAIL drain_timeout: %0d entries still in flight, expected 0", mq.size());
    end
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++; if (req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
    n_checks++; if (req_addr !== '0) begin n_errors++; $display("FAIL reset_req_addr: got %h expected 0", req_addr); end
    n_checks++; if (req_tag !== '0) begin n_errors++; $display("FAIL reset_req_tag: got %h expected 0", req_tag); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL reset_pc_ready: got %b expected 1", pc_ready); end
    model_reset();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    int t;
    idle();
    pc_valid = 1'b1; pc_addr = 32'h100; pc_warp_num = 5'd3; pc_split_num = 3'd1;
    t = m_alloc_cnt % int'(MAXO);
    #1;
    n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL single_pc_ready: got %b expected 1", pc_ready); end
    tick();
    pc_valid = 1'b0;
    #1;
    n_checks++; if (req_valid !== 1'b1) begin n_errors++; $display("FAIL single_req_valid: got %b expected 1", req_valid); end
    n_checks++; if (req_addr !== 32'h100) begin n_errors++; $display("FAIL single_req_addr: got %h expected 100", req_addr); end
    n_checks++; if (req_tag !== TW'(t)) begin n_errors++; $display("FAIL single_req_tag: got %0d expected %0d", req_tag, t); end
    tick();
    #1;
    n_checks++; if (req_valid !== 1'b0) begin n_errors++; $display("FAIL single_req_drop: got %b expected 0", req_valid); end
    tick();
    respond(t, 32'hDEADBEEF);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_early_out: got %b expected 0", out_valid); end
    tick();
    rsp_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL single_out_valid: got %b expected 1", out_valid); end
    n_checks++;
    if (out_pc !== 32'h100 || out_warp_num !== 5'd3 || out_split_num !== 3'd1 || out_inst !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL single_out_beat: got {%h,%0d,%0d,%h} expected {100,3,1,deadbeef}", out_pc, out_warp_num, out_split_num, out_inst);
    end
    tick();
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_retired: got %b expected 0", out_valid); end
  endtask

  task automatic test_out_of_order();
    int            tags[3];
    int            sched[3];
    logic [AW-1:0] got[$];
    idle();
    for (int i = 0; i < 3; i++) begin
      pc_valid = 1'b1; pc_addr = AW'(i * 4); pc_warp_num = WW'(i); tags[i] = m_alloc_cnt % int'(MAXO);
      #1;
      n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL ooo_pc_ready%0d: got %b expected 1", i, pc_ready); end
      tick();
    end
    pc_valid = 1'b0;
    tick();
    sched[0] = tags[2]; sched[1] = tags[0]; sched[2] = tags[1];
    for (int c = 0; c < 10; c++) begin
      if (c < 3) respond(sched[c], IW'(32'hA000 + c)); else rsp_valid = 1'b0;
      #1;
      if (c == 1) begin
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL ooo_head_blocked: got %b expected 0", out_valid); end
      end
      if (out_valid === 1'b1) got.push_back(out_pc);
      tick();
    end
    rsp_valid = 1'b0;
    n_checks++; if (got.size() != 3) begin n_errors++; $display("FAIL ooo_beat_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        n_checks++; if (got[i] !== AW'(i * 4)) begin n_errors++; $display("FAIL ooo_order%0d: got %h expected %h", i, got[i], i * 4); end
      end
    end
  endtask

  task automatic test_full();
    int tags[4];
    idle();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc_valid = 1'b1; pc_addr = AW'(32'h1000 + i * 4); tags[i] = m_alloc_cnt % int'(MAXO);
      #1;
      n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL full_fill%0d: got %b expected 1", i, pc_ready); end
      tick();
    end
    pc_addr = 32'h2000;
    #1;
    n_checks++; if (pc_ready !== 1'b0) begin n_errors++; $display("FAIL full_pc_ready: got %b expected 0", pc_ready); end
    tick();
    respond(tags[0], 32'h1234);
    tick();
    rsp_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL full_head_out: got %b expected 1", out_valid); end
    n_checks++; if (pc_ready !== 1'b0) begin n_errors++; $display("FAIL full_retire_same_cycle: got %b expected 0", pc_ready); end
    tick();
    pc_valid = 1'b0;
    #1;
    n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL full_after_retire: got %b expected 1", pc_ready); end
    drain();
  endtask

  task automatic test_backpressure();
    int t;
    idle();
    req_ready = 1'b0; out_ready = 1'b0;
    pc_valid = 1'b1; pc_addr = 32'h200; pc_warp_num = 5'd7; pc_split_num = 3'd5;
    t = m_alloc_cnt % int'(MAXO);
    tick();
    pc_addr = 32'h300;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (req_valid !== 1'b1 || req_addr !== 32'h200 || req_tag !== TW'(t)) begin
        n_errors++; $display("FAIL bp_req_hold%0d: got {%b,%h,%0d} expected {1,200,%0d}", c, req_valid, req_addr, req_tag, t);
      end
      n_checks++; if (pc_ready !== 1'b0) begin n_errors++; $display("FAIL bp_pc_blocked%0d: got %b expected 0", c, pc_ready); end
      tick();
    end
    pc_valid = 1'b0; req_ready = 1'b1;
    tick();
    respond(t, 32'hCAFEF00D);
    tick();
    rsp_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_warp_num !== 5'd7 || out_split_num !== 3'd5 || out_inst !== 32'hCAFEF00D) begin
        n_errors++; $display("FAIL bp_out_hold%0d: got {%b,%h,%0d,%0d,%h} expected {1,200,7,5,cafef00d}", c, out_valid, out_pc, out_warp_num, out_split_num, out_inst);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_released: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    int n_beats;
    idle();
    for (int i = 0; i < 3; i++) begin
      pc_valid = 1'b1; pc_addr = AW'(32'h400 + i * 4);
      tick();
    end
    pc_valid = 1'b0; req_ready = 1'b0; flush = 1'b1;
    #1;
    n_checks++; if (pc_ready !== 1'b0) begin n_errors++; $display("FAIL flush_pc_ready: got %b expected 0", pc_ready); end
    tick();
    flush = 1'b0; req_ready = 1'b1;
    #1;
    n_checks++; if (req_valid !== 1'b0) begin n_errors++; $display("FAIL flush_req_dropped: got %b expected 0", req_valid); end
    for (int c = 0; c < 10; c++) begin
      if (cache_q.size() > 0) respond(cache_q[0], $urandom); else rsp_valid = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_squashed_out%0d: got %b expected 0", c, out_valid); end
      tick();
    end
    rsp_valid = 1'b0;
    pc_valid = 1'b1; pc_addr = 32'h500; pc_warp_num = 5'd2; pc_split_num = 3'd4;
    #1;
    n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL flush_new_pc_ready: got %b expected 1", pc_ready); end
    tick();
    pc_valid = 1'b0;
    n_beats = 0;
    for (int c = 0; c < 8; c++) begin
      if (cache_q.size() > 0) respond(cache_q[0], 32'h5A5A5A5A); else rsp_valid = 1'b0;
      #1;
      if (out_valid === 1'b1) begin
        n_beats++;
        n_checks++; if (out_pc !== 32'h500 || out_warp_num !== 5'd2 || out_inst !== 32'h5A5A5A5A) begin
          n_errors++; $display("FAIL flush_new_beat: got {%h,%0d,%h} expected {500,2,5a5a5a5a}", out_pc, out_warp_num, out_inst);
        end
      end
      tick();
    end
    rsp_valid = 1'b0;
    n_checks++; if (n_beats != 1) begin n_errors++; $display("FAIL flush_new_beat_count: got %0d expected 1", n_beats); end
  endtask

  task automatic test_reset_midflight();
    idle();
    for (int i = 0; i < 2; i++) begin
      pc_valid = 1'b1; pc_addr = AW'(32'h600 + i * 4);
      tick();
    end
    pc_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++; if (req_valid !== 1'b0 || req_addr !== '0 || req_tag !== '0) begin
      n_errors++; $display("FAIL rst_mid_req: got {%b,%h,%0d} expected {0,0,0}", req_valid, req_addr, req_tag);
    end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL rst_mid_pc_ready: got %b expected 1", pc_ready); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (cache_q.size() > 0) respond(cache_q[0], 32'hBAD0BAD0); else rsp_valid = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_stale%0d: got %b expected 0", c, out_valid); end
      tick();
    end
    rsp_valid = 1'b0;
  endtask

  task automatic test_random();
    int k;
    for (int c = 0; c < 3000; c++) begin
      rdy          = ($urandom_range(9) != 0);
      flush        = ($urandom_range(39) == 0);
      pc_valid     = ($urandom_range(4) < 3);
      pc_addr      = $urandom;
      pc_warp_num  = WW'($urandom);
      pc_split_num = SW'($urandom);
      req_ready    = ($urandom_range(3) != 0);
      out_ready    = ($urandom_range(3) != 0);
      rsp_valid    = 1'b0;
      if (rdy && cache_q.size() > 0 && $urandom_range(2) != 0) begin
        k = $urandom_range(cache_q.size() - 1);
        respond(cache_q[k], $urandom);
      end
      #1;
      n_checks++; if (pc_ready !== exp_pc_ready()) begin n_errors++; $display("FAIL rnd_pc_ready@%0d: got %b expected %b", c, pc_ready, exp_pc_ready()); end
      n_checks++; if (req_valid !== m_req_v) begin n_errors++; $display("FAIL rnd_req_valid@%0d: got %b expected %b", c, req_valid, m_req_v); end
      if (m_req_v) begin
        n_checks++; if (req_addr !== m_req_addr || req_tag !== TW'(m_req_tag)) begin
          n_errors++; $display("FAIL rnd_req@%0d: got {%h,%0d} expected {%h,%0d}", c, req_addr, req_tag, m_req_addr, m_req_tag);
        end
      end
      n_checks++; if (out_valid !== exp_out_valid()) begin n_errors++; $display("FAIL rnd_out_valid@%0d: got %b expected %b", c, out_valid, exp_out_valid()); end
      if (exp_out_valid()) begin
        n_checks++;
        if (out_pc !== mq[0].pc || out_warp_num !== mq[0].warp || out_split_num !== mq[0].split || out_inst !== mq[0].inst) begin
          n_errors++; $display("FAIL rnd_out@%0d: got {%h,%0d,%0d,%h} expected {%h,%0d,%0d,%h}", c, out_pc, out_warp_num, out_split_num, out_inst, mq[0].pc, mq[0].warp, mq[0].split, mq[0].inst);
        end
      end
      tick();
    end
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_single_fetch();
    drain();
    test_out_of_order();
    drain();
    test_full();
    test_backpressure();
    drain();
    test_flush();
    drain();
    test_reset_midflight();
    drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
